// File: rtl/mp_register_file.sv
// mp_register_file: multi-read-port register file with two write ports and a
// pending-writeback scoreboard.
//
// Parameters: XLEN (data width), NREGS (register count, power of two),
//             NRD (read ports), ZERO_REG (1 = register 0 is hard-wired zero).
// Ports:
//   clk, rst (async, active-low)
//   rd_addr/rd_data/rd_pending  packed per read port, combinational reads
//   wr0_*/wr1_*                 write ports, port 1 wins on address collision
//   issue_en/issue_addr         mark destination register pending
//   flush                       clear all pending bits
//   pending_count               registered popcount of the pending vector
// Optional build macro: REGFILE_BYPASS_EN -- same-cycle write data is
// forwarded to matching read ports (and their pending bit reads 0).

// One read port: registered value/pending bit, optional forwarded override,
// then forced to zero for register 0 (when hard-wired) and while in reset.
module mp_rf_rd_lane #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int AW       = 5
) (
  input  logic                        rst,
  input  logic [AW-1:0]               addr,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            pend,
  input  logic                        byp_vld,
  input  logic [XLEN-1:0]             byp_data,
  output logic [XLEN-1:0]             data,
  output logic                        pending
);
  always_comb begin
    data    = regs[addr];
    pending = pend[addr];
    if (byp_vld) begin
      data    = byp_data;
      pending = 1'b0;
    end
    // reset gating matters only for forwarded data; state is already zero
    if (!rst || (ZERO_REG != 0 && addr == '0)) begin
      data    = '0;
      pending = 1'b0;
    end
  end
endmodule

module mp_register_file #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_pending,
  input  logic                 wr0_en,
  input  logic [AW-1:0]        wr0_addr,
  input  logic [XLEN-1:0]      wr0_data,
  input  logic                 wr1_en,
  input  logic [AW-1:0]        wr1_addr,
  input  logic [XLEN-1:0]      wr1_data,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_addr,
  input  logic                 flush,
  output logic [AW:0]          pending_count
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           pend, pend_nxt;
  logic                       wr0_ok, wr1_ok, iss_ok;

  // accesses to a hard-wired register 0 are dropped at the source
  assign wr0_ok = wr0_en   && !(ZERO_REG != 0 && wr0_addr   == '0);
  assign wr1_ok = wr1_en   && !(ZERO_REG != 0 && wr1_addr   == '0);
  assign iss_ok = issue_en && !(ZERO_REG != 0 && issue_addr == '0);

  function automatic logic [AW:0] popcnt(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int k = 0; k < NREGS; k++) c += {{AW{1'b0}}, v[k]};
    return c;
  endfunction

  // port 1 is applied last so it wins a same-address collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
    end else begin
      if (wr0_ok) regs[wr0_addr] <= wr0_data;
      if (wr1_ok) regs[wr1_addr] <= wr1_data;
    end
  end

  // writeback clears, issue sets afterwards (issue wins), flush overrides all
  always_comb begin
    pend_nxt = pend;
    if (wr0_ok) pend_nxt[wr0_addr]   = 1'b0;
    if (wr1_ok) pend_nxt[wr1_addr]   = 1'b0;
    if (iss_ok) pend_nxt[issue_addr] = 1'b1;
    if (flush)  pend_nxt             = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend          <= '0;
      pending_count <= '0;
    end else begin
      pend          <= pend_nxt;
      pending_count <= popcnt(pend_nxt);
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic            byp_vld;
    logic [XLEN-1:0] byp_data;

    assign a = rd_addr[i*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    always_comb begin
      byp_vld  = 1'b0;
      byp_data = '0;
      if (wr1_ok && wr1_addr == a) begin
        byp_vld  = 1'b1;
        byp_data = wr1_data;
      end else if (wr0_ok && wr0_addr == a) begin
        byp_vld  = 1'b1;
        byp_data = wr0_data;
      end
    end
`else
    assign byp_vld  = 1'b0;
    assign byp_data = '0;
`endif

    mp_rf_rd_lane #(
      .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .AW(AW)
    ) u_lane (
      .rst     (rst),
      .addr    (a),
      .regs    (regs),
      .pend    (pend),
      .byp_vld (byp_vld),
      .byp_data(byp_data),
      .data    (rd_data[i*XLEN +: XLEN]),
      .pending (rd_pending[i])
    );
  end
endmodule

// File: tb/tb_mp_register_file.sv
module tb_mp_register_file;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic        wr0_en, wr1_en, issue_en, flush;
  logic [4:0]  wr0_addr, wr1_addr, issue_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [5:0]  pending_count;

  mp_register_file dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_pending(rd_pending), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
    .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .issue_en(issue_en), .issue_addr(issue_addr),
    .flush(flush), .pending_count(pending_count)
  );

  // wide / no zero register instance
  logic [11:0]  d2_rd_addr;
  logic [191:0] d2_rd_data;
  logic [2:0]   d2_rd_pending;
  logic         d2_wr0_en, d2_wr1_en, d2_issue_en, d2_flush;
  logic [3:0]   d2_wr0_addr, d2_wr1_addr, d2_issue_addr;
  logic [63:0]  d2_wr0_data, d2_wr1_data;
  logic [4:0]   d2_pending_count;

  mp_register_file #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) dut2 (
    .clk(clk), .rst(rst), .rd_addr(d2_rd_addr), .rd_data(d2_rd_data),
    .rd_pending(d2_rd_pending), .wr0_en(d2_wr0_en), .wr0_addr(d2_wr0_addr),
    .wr0_data(d2_wr0_data), .wr1_en(d2_wr1_en), .wr1_addr(d2_wr1_addr),
    .wr1_data(d2_wr1_data), .issue_en(d2_issue_en), .issue_addr(d2_issue_addr),
    .flush(d2_flush), .pending_count(d2_pending_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: arrays of values and pending flags
  logic [31:0] m_regs[32];
  bit          m_pend[32];

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      m_regs[k] = '0;
      m_pend[k] = 1'b0;
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < 32; k++) c += int'(m_pend[k]);
    return c;
  endfunction

  task automatic model_edge();
    if (wr0_en && wr0_addr != 0) begin m_regs[wr0_addr] = wr0_data; m_pend[wr0_addr] = 1'b0; end
    if (wr1_en && wr1_addr != 0) begin m_regs[wr1_addr] = wr1_data; m_pend[wr1_addr] = 1'b0; end
    if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    if (flush) for (int k = 0; k < 32; k++) m_pend[k] = 1'b0;
  endtask

  task automatic exp_read(input int a, output logic [31:0] d, output logic p);
    d = '0;
    p = 1'b0;
    if (a != 0) begin
      d = m_regs[a];
      p = m_pend[a];
      if (BYP) begin
        if (wr1_en && wr1_addr == a) begin d = wr1_data; p = 1'b0; end
        else if (wr0_en && wr0_addr == a) begin d = wr0_data; p = 1'b0; end
      end
    end
  endtask

  // inputs are driven just after a falling edge; checks reads, takes the edge,
  // advances the model, checks the count, returns at the next falling edge
  task automatic cycle();
    logic [31:0] d;
    logic        p;
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_read(int'(rd_addr[i*5 +: 5]), d, p);
      chk($sformatf("model_rd_data%0d", i), rd_data[i*32 +: 32], d);
      chk($sformatf("model_rd_pend%0d", i), rd_pending[i], p);
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("model_count", pending_count, m_count());
    @(negedge clk);
  endtask

  task automatic idle();
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    issue_en = 0; issue_addr = 0; flush = 0;
    d2_wr0_en = 0; d2_wr0_addr = 0; d2_wr0_data = 0;
    d2_wr1_en = 0; d2_wr1_addr = 0; d2_wr1_data = 0;
    d2_issue_en = 0; d2_issue_addr = 0; d2_flush = 0;
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  // ---------------- directed vector table
  typedef struct {
    logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
    logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
    logic        ie;  logic [4:0] ia;  logic fl;
    logic [4:0]  ra;
    logic [31:0] exp_d; logic exp_p; int exp_cnt;
  } vec_t;

  function automatic vec_t mk(logic w0e, logic [4:0] w0a, logic [31:0] w0d,
                              logic w1e, logic [4:0] w1a, logic [31:0] w1d,
                              logic ie, logic [4:0] ia, logic fl, logic [4:0] ra,
                              logic [31:0] ed, logic ep, int ec);
    vec_t v;
    v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
    v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
    v.ie = ie; v.ia = ia; v.fl = fl; v.ra = ra;
    v.exp_d = ed; v.exp_p = ep; v.exp_cnt = ec;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = mk(1, 5, 32'hAAAA_0000, 1, 5, 32'h5555_1111, 0, 0, 0, 5, BYP ? 32'h5555_1111 : 32'h0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'h5555_1111, 0, 0);
    tbl[2]  = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 32'h0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 3, 32'h0, 1, 2);
    tbl[6]  = mk(1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 3, BYP ? 32'h33 : 32'h0, !BYP, 1);
    tbl[7]  = mk(0, 0, 0, 1, 7, 32'h77, 1, 7, 0, 7, BYP ? 32'h77 : 32'h0, !BYP, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h77, 1, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 9, 1, 7, 32'h77, 1, 0);
    tbl[10] = mk(1, 9, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 9, BYP ? 32'h1234_5678 : 32'h0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h1234_5678, 0, 0);

    idle();
    rd_addr = '0;
    d2_rd_addr = '0;
    model_reset();

    // reset state
    #3;
    chk("reset_rd_data", rd_data, 64'h0);
    chk("reset_rd_pend", rd_pending, 2'b00);
    chk("reset_count", pending_count, 6'd0);
    chk("reset_d2_count", d2_pending_count, 5'd0);
    @(negedge clk);
    rst = 1'b1;

    // directed table
    for (int t = 0; t < 12; t++) begin
      wr0_en = tbl[t].w0e; wr0_addr = tbl[t].w0a; wr0_data = tbl[t].w0d;
      wr1_en = tbl[t].w1e; wr1_addr = tbl[t].w1a; wr1_data = tbl[t].w1d;
      issue_en = tbl[t].ie; issue_addr = tbl[t].ia; flush = tbl[t].fl;
      rd_addr = {tbl[t].ra, tbl[t].ra};
      #1;
      chk($sformatf("vec%0d_rd0", t), rd_data[31:0], tbl[t].exp_d);
      chk($sformatf("vec%0d_rd1", t), rd_data[63:32], tbl[t].exp_d);
      chk($sformatf("vec%0d_pend0", t), rd_pending[0], tbl[t].exp_p);
      chk($sformatf("vec%0d_pend1", t), rd_pending[1], tbl[t].exp_p);
      cycle();
      chk($sformatf("vec%0d_count", t), pending_count, 6'(tbl[t].exp_cnt));
    end
    idle();

    // wide instance: address 0 writable and issuable, three independent ports
    d2_wr0_en = 1; d2_wr0_addr = 0;  d2_wr0_data = 64'hDEAD_BEEF_0123_4567;
    d2_wr1_en = 1; d2_wr1_addr = 15; d2_wr1_data = 64'hFEDC_BA98_7654_3210;
    d2_issue_en = 1; d2_issue_addr = 0;
    @(posedge clk); #1;
    chk("d2_count_issue0", d2_pending_count, 5'd1);
    @(negedge clk);
    idle();
    d2_rd_addr = {4'd15, 4'd15, 4'd0};
    #1;
    chk("d2_rd_p0", d2_rd_data[63:0],    64'hDEAD_BEEF_0123_4567);
    chk("d2_rd_p1", d2_rd_data[127:64],  64'hFEDC_BA98_7654_3210);
    chk("d2_rd_p2", d2_rd_data[191:128], 64'hFEDC_BA98_7654_3210);
    chk("d2_pend",  d2_rd_pending, 3'b001);
    d2_wr1_en = 1; d2_wr1_addr = 0; d2_wr1_data = 64'h0BAD_F00D_CAFE_0001;
    @(posedge clk); #1;
    chk("d2_count_wb0", d2_pending_count, 5'd0);
    chk("d2_rd_p0_new", d2_rd_data[63:0], 64'h0BAD_F00D_CAFE_0001);
    @(negedge clk);
    idle();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      wr0_en = 1'($urandom_range(0, 1)); wr0_addr = raddr(); wr0_data = $urandom();
      wr1_en = 1'($urandom_range(0, 2) == 0); wr1_addr = raddr(); wr1_data = $urandom();
      issue_en = 1'($urandom_range(0, 1)); issue_addr = raddr();
      flush = 1'($urandom_range(0, 31) == 0);
      rd_addr = {raddr(), raddr()};
      cycle();
    end

    // asynchronous reset mid-traffic, with writes/issues active through it
    wr0_en = 1; wr0_addr = 5'd4; wr0_data = 32'hCAFE_BABE;
    issue_en = 1; issue_addr = 5'd6;
    rd_addr = {5'd6, 5'd4};
    #2 rst = 1'b0;
    #1;
    chk("async_rst_rd_data", rd_data, 64'h0);
    chk("async_rst_pend", rd_pending, 2'b00);
    chk("async_rst_count", pending_count, 6'd0);
    @(posedge clk); #1;
    chk("rst_held_rd_data", rd_data, 64'h0);
    chk("rst_held_count", pending_count, 6'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle();
    rd_addr = {5'd6, 5'd4};
    cycle();
    // first edge after reset behaves normally
    wr0_en = 1; wr0_addr = 5'd4; wr0_data = 32'h0F0F_1234;
    issue_en = 1; issue_addr = 5'd6;
    cycle();
    idle();
    cycle();
    chk("post_rst_rd4", rd_data[31:0], 32'h0F0F_1234);
    chk("post_rst_count", pending_count, 6'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
